multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Multi-cycle wide adder/subtractor. Accepts one wide operand pair over a valid/ready handshake.
- Slices the operands into CHUNK_WIDTH chunks and feeds one chunk per cycle, LSB chunk first, into a single combinational Kogge-Stone adder instance.
- Chains the carry between chunks through a register.
- Returns the full-width result over a second valid/ready handshake. Sits directly upstream of, and drives, the prefix adder datapath; trades latency for area on wide ALU operations.

Parameters:
- CHUNK_WIDTH, 32, width of each adder slice; the adder instance is built at this width.
- NUM_CHUNKS, 4, number of slices; total width W = CHUNK_WIDTH*NUM_CHUNKS; must be ≥ 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in for add mode; ignored in subtract mode.
- in_sub  input  1  1 = compute A−B, 0 = compute A+B+cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  result.
- out_cout  output  1  carry-out; in subtract mode 1 = no borrow (A ≥ B unsigned).
- out_overflow  output  1  two's-complement signed overflow of the W-bit operation.
- out_zero  output  1  out_sum == 0.

Behaviour:
- Interface: one clock domain; reset is synchronous and active-high. Clock and reset ports are named clk and rst.
- FSM states: IDLE, RUN, DONE.
- Reset (sampled at the clk edge while rst=1):
  - state=IDLE, chunk index=0, carry register=0.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, out_sum=0, out_cout=0, out_overflow=0, out_zero=0.
  - Reset aborts any operation in flight; no partial result is ever presented.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, register:
    - in_a;
    - b_eff = in_sub ? ~in_b : in_b;
    - carry = in_sub ? 1 : in_cin.
  - Then go to RUN with index=0.
- RUN:
  - in_ready=0.
  - Each cycle the adder adds chunk[index] of A and b_eff with the carry register.
  - At the edge: write the result into the sum register chunk[index], load the adder cout into the carry register, index++.
  - When index==NUM_CHUNKS−1, go to DONE instead.
- DONE:
  - out_valid=1; out_sum, out_cout, out_overflow and out_zero are registered and stable.
  - Outputs hold while out_ready=0, for an unbounded time.
  - On out_valid&&out_ready, go to IDLE; out_valid=0 in the next cycle.
- Latency: out_valid rises exactly NUM_CHUNKS cycles after the input handshake edge.
- Throughput: one operation per NUM_CHUNKS+2 cycles. No acceptance while RUN or DONE; in_valid in those states is ignored and not queued.
- Flag rules:
  - out_cout = carry out of the top chunk.
  - out_overflow = (A[W−1]==b_eff[W−1]) && (out_sum[W−1]!=A[W−1]).
  - out_zero is computed from the final registered sum.
  - All flags are valid only while out_valid=1; they are held at their last value otherwise.
- Wrap-around: the sum is modulo 2^W. Carry out of chunk k feeds only chunk k+1; there is no end-around carry.
- in_a, in_b and in_sub may change freely after the handshake; the block works only from registered copies.
- rst and a handshake in the same cycle: rst wins; the operand pair is dropped.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/RUN/DONE).
  - Chunk-index width constant = $clog2(NUM_CHUNKS).
  - Derived width function W = CHUNK_WIDTH*NUM_CHUNKS.
- One sub-module: configurable_kogge_stone_adder, instantiated once with DATA_WIDTH=CHUNK_WIDTH; its cin comes from the carry register.
- FSM, operand/sum registers and flag logic live in the top module.

Test Plan (CHUNK_WIDTH=32, NUM_CHUNKS=4, W=128):
- Full-width carry ripple:
  - Stimulus: add, A=0xFFFF…FFFF (128b), B=1, cin=0.
  - Required: out_sum=0, out_cout=1, out_zero=1, out_overflow=0; out_valid 4 cycles after handshake.
- Partial chain:
  - Stimulus: add, A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1.
  - Required: out_sum=0x00000001_00000000_00000000_00000000, out_cout=0.
- Subtract with borrow:
  - Stimulus: sub, A=5, B=7.
  - Required: out_sum=0xFFFF…FFFE, out_cout=0, out_overflow=0, out_zero=0.
- Signed overflow:
  - Stimulus: add, A=0x7FFF…FFFF, B=1.
  - Required: out_sum=0x8000…0000, out_overflow=1, out_cout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands.
  - Required: outputs stable, in_ready=0, new operands not taken. After out_ready=1: in_ready=1 the next cycle, then the next operation completes correctly.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle after the 2nd chunk of a RUN.
  - Required: out_valid never asserts for that operation; in_ready=1 the next cycle; a following add 1+1 gives out_sum=2.

Source files
------------

// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and sizing helpers for the multi-cycle wide adder/subtractor.
//   state_e      : sequencer FSM states (idle, running over chunks, result held)
//   total_width  : full operand width from chunk width and chunk count
//   idx_width    : width of the chunk-index counter
package multiword_add_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefChunkWidth = 32;
  localparam int unsigned DefNumChunks  = 4;

  function automatic int unsigned total_width(input int unsigned chunk_width,
                                              input int unsigned num_chunks);
    return chunk_width * num_chunks;
  endfunction

  // A single-chunk build still needs a one-bit index.
  function automatic int unsigned idx_width(input int unsigned num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

  localparam int unsigned DefIdxWidth = idx_width(DefNumChunks);

endpackage

// File: rtl/configurable_kogge_stone_adder.sv
// Combinational Kogge-Stone parallel-prefix adder.
//   a_i, b_i : DATA_WIDTH-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : DATA_WIDTH-bit sum
//   cout_o   : carry out of the top bit
module configurable_kogge_stone_adder #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  cin_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  cout_o
);

  localparam int unsigned Levels = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 0;

  logic [DATA_WIDTH-1:0] prop;
  logic [DATA_WIDTH-1:0] gen;
  logic [DATA_WIDTH-1:0] grp_p;
  logic [DATA_WIDTH-1:0] gen_nxt;
  logic [DATA_WIDTH-1:0] grp_p_nxt;
  logic [DATA_WIDTH-1:0] carry;

  always_comb begin
    prop      = a_i ^ b_i;
    gen       = a_i & b_i;
    grp_p     = prop;
    gen_nxt   = '0;
    grp_p_nxt = '0;
    carry     = '0;
    // Fold carry-in into bit 0 so the prefix tree needs no extra column.
    gen[0]    = gen[0] | (prop[0] & cin_i);
    for (int l = 0; l < int'(Levels); l++) begin
      gen_nxt   = gen;
      grp_p_nxt = grp_p;
      for (int i = (1 << l); i < int'(DATA_WIDTH); i++) begin
        gen_nxt[i]   = gen[i] | (grp_p[i] & gen[i-(1<<l)]);
        grp_p_nxt[i] = grp_p[i] & grp_p[i-(1<<l)];
      end
      gen   = gen_nxt;
      grp_p = grp_p_nxt;
    end
    // gen[i] is now the carry out of bit i.
    carry[0] = cin_i;
    for (int i = 1; i < int'(DATA_WIDTH); i++) begin
      carry[i] = gen[i-1];
    end
    sum_o  = prop ^ carry;
    cout_o = gen[DATA_WIDTH-1];
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-cycle wide adder/subtractor. Accepts one W-bit operand pair, runs it through a single
// CHUNK_WIDTH-bit Kogge-Stone adder one chunk per cycle (LSB chunk first, carry chained through
// a register) and presents the full-width result with flags.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (in_a, in_b, in_cin, in_sub)
//   out_valid/out_ready : result handshake (out_sum, out_cout, out_overflow, out_zero)
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned CHUNK_WIDTH = DefChunkWidth,
  parameter int unsigned NUM_CHUNKS  = DefNumChunks
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [total_width(CHUNK_WIDTH, NUM_CHUNKS)-1:0] in_a,
  input  logic [total_width(CHUNK_WIDTH, NUM_CHUNKS)-1:0] in_b,
  input  logic                                            in_cin,
  input  logic                                            in_sub,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [total_width(CHUNK_WIDTH, NUM_CHUNKS)-1:0] out_sum,
  output logic                                            out_cout,
  output logic                                            out_overflow,
  output logic                                            out_zero
);

  localparam int unsigned W       = total_width(CHUNK_WIDTH, NUM_CHUNKS);
  localparam int unsigned IdxW    = idx_width(NUM_CHUNKS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK_WIDTH-1:0] add_sum;
  logic                   add_cout;

  // Operands shift right one chunk per cycle, so the active chunk is always the low slice.
  configurable_kogge_stone_adder #(
    .DATA_WIDTH(CHUNK_WIDTH)
  ) u_adder (
    .a_i   (a_q[CHUNK_WIDTH-1:0]),
    .b_i   (b_q[CHUNK_WIDTH-1:0]),
    .cin_i (carry_q),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK_WIDTH;
        b_d     = b_q >> CHUNK_WIDTH;
        // Each chunk result enters at the top; after NUM_CHUNKS shifts chunk 0 sits at the bottom.
        sum_d   = {add_sum, sum_q[W-1:CHUNK_WIDTH]};
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
          cout_d  = add_cout;
          // Low slice of the shifted operands now holds the original top chunk.
          ovf_d   = (a_q[CHUNK_WIDTH-1] == b_q[CHUNK_WIDTH-1]) &&
                    (add_sum[CHUNK_WIDTH-1] != a_q[CHUNK_WIDTH-1]);
          zero_d  = (sum_d == '0);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign out_sum      = sum_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int unsigned CW = 32;
  localparam int unsigned NC = 4;
  localparam int unsigned W  = CW * NC;

  localparam logic [W-1:0] AllOnes = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_overflow;
  logic         out_zero;

  int errors = 0;
  int checks = 0;

  multiword_add_sequencer #(
    .CHUNK_WIDTH(CW),
    .NUM_CHUNKS (NC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .in_sub      (in_sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_cout    (out_cout),
    .out_overflow(out_overflow),
    .out_zero    (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until out_valid rises, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      step();
      cycles++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input logic exp_ovf, input logic exp_zero);
    int cyc;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    step();
    // Scramble inputs: the block must work from its registered copies.
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_cin   = ~cin;
    in_sub   = ~sub;
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, NC);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_cout"}, out_cout, exp_cout);
    check({tag, "_ovf"}, out_overflow, exp_ovf);
    check({tag, "_zero"}, out_zero, exp_zero);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    logic seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_ovf", out_overflow, 0);
    check("rst_zero", out_zero, 0);

    do_op("ripple", AllOnes, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0, 1'b1);
    do_op("partial", 128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
          128'h00000001_00000000_00000000_00000000, 1'b0, 1'b0, 1'b0);
    do_op("sub_borrow", 128'd5, 128'd7, 1'b0, 1'b1,
          128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, 1'b0, 1'b0, 1'b0);
    do_op("signed_ovf", 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0,
          128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1, 1'b0);
    do_op("add_cin", 128'd3, 128'd4, 1'b1, 1'b0, 128'd8, 1'b0, 1'b0, 1'b0);
    // cin must be ignored when subtracting.
    do_op("sub_noborrow", 128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1, 1'b0, 1'b0);
    do_op("sub_equal", 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
          128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b0, 1'b1, 128'd0, 1'b1, 1'b0, 1'b1);
    // Carry crosses chunk 0->1 only.
    do_op("mid_chain", 128'h00000000_00000000_00000000_80000000,
          128'h00000000_00000000_00000000_80000000, 1'b0, 1'b0,
          128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0, 1'b0);
    do_op("neg_ovf", 128'h80000000_00000000_00000000_00000000, AllOnes, 1'b0, 1'b0,
          128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    in_valid = 1'b1;
    in_a     = 128'd10;
    in_b     = 128'd20;
    in_cin   = 1'b0;
    in_sub   = 1'b0;
    step();
    in_a = 128'd55;
    in_b = 128'd66;
    wait_valid(cyc);
    check("bp_latency", cyc, NC);
    check("bp_sum_first", out_sum, 128'd30);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid_hold", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sum_hold", out_sum, 128'd30);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready_back", in_ready, 1);
    do_op("bp_next", 128'd100, 128'd1, 1'b0, 1'b0, 128'd101, 1'b0, 1'b0, 1'b0);

    // Reset after two chunks of a running operation.
    in_valid = 1'b1;
    in_a     = AllOnes;
    in_b     = 128'd1;
    in_sub   = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_sum", out_sum, 0);
    seen = 1'b0;
    repeat (NC + 2) begin
      step();
      seen |= out_valid;
    end
    check("rst_mid_no_result", seen, 0);

    // Reset coincident with a handshake: operands dropped.
    in_valid = 1'b1;
    in_a     = 128'd9;
    in_b     = 128'd9;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    seen     = 1'b0;
    repeat (NC + 2) begin
      step();
      seen |= out_valid;
    end
    check("rst_hs_no_result", seen, 0);

    do_op("after_rst", 128'd1, 128'd1, 1'b0, 1'b0, 128'd2, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
